// File: rtl/cnn_argmax_result.sv
// cnn_argmax_result
//   Captures the dense-3 score write stream, then scans the stored scores one
//   index per cycle to find the winning class (signed max, ties to lowest
//   index). The result is held until the next start.
// Ports
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle pulse, arms capture (also aborts a run)
//   wr_en/wr_addr/wr_data dense-3 write stream (class index, signed score)
//   layer_fin             dense-3 finished level, sampled in COLLECT only
//   res, res_valid, done  winning index (8'hFF = none), valid level, pulse
//   max_score             score of the winning class
//   busy                  high in COLLECT and SCAN
//   err                   sticky {missing, duplicate, out_of_range}
module cnn_argmax_result #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  layer_fin,
  output logic [7:0]            res,
  output logic                  res_valid,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] max_score,
  output logic                  busy,
  output logic [2:0]            err
);

  // idx must reach NUM_CLASSES: that extra SCAN cycle registers the result
  localparam int IW = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN, S_DONE} state_t;

  state_t                                state;
  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] score;
  logic [NUM_CLASSES-1:0]                mask;
  logic [NUM_CLASSES-1:0]                hit;
  logic                                  in_range;
  logic [IW-1:0]                         idx;
  logic [7:0]                            best_idx;
  logic signed [DATA_WIDTH-1:0]          best_score;
  logic                                  best_found;
  logic signed [DATA_WIDTH-1:0]          cur_score;
  logic                                  cur_mask;
  logic                                  take;

  // Full-width address decode: high address bits must not alias a class
  always_comb begin
    hit      = '0;
    in_range = (wr_addr < ADDR_WIDTH'(NUM_CLASSES));
    for (int i = 0; i < NUM_CLASSES; i++)
      hit[i] = (wr_addr == ADDR_WIDTH'(i));
  end

  // Scan read port; idx == NUM_CLASSES selects nothing
  always_comb begin
    cur_score = '0;
    cur_mask  = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (idx == IW'(i)) begin
        cur_score = score[i];
        cur_mask  = mask[i];
      end
    // strict > keeps the lowest index on ties
    take = cur_mask && (!best_found || (cur_score > best_score));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      score      <= '0;
      mask       <= '0;
      idx        <= '0;
      best_idx   <= '0;
      best_score <= '0;
      best_found <= 1'b0;
      res        <= '0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
      max_score  <= '0;
      busy       <= 1'b0;
      err        <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // entry to COLLECT from any state, including abort
        state     <= S_COLLECT;
        mask      <= '0;
        err       <= '0;
        res_valid <= 1'b0;
        res       <= 8'hFF;
        busy      <= 1'b1;
      end else begin
        case (state)
          S_COLLECT: begin
            if (wr_en) begin
              if (in_range) begin
                for (int i = 0; i < NUM_CLASSES; i++)
                  if (hit[i]) score[i] <= wr_data;
                mask <= mask | hit;
                if (|(mask & hit)) err[1] <= 1'b1;
              end else begin
                err[0] <= 1'b1;
              end
            end
            if (layer_fin) begin
              state      <= S_SCAN;
              idx        <= '0;
              best_found <= 1'b0;
              best_idx   <= '0;
              best_score <= '0;
            end
          end
          S_SCAN: begin
            if (idx == IW'(NUM_CLASSES)) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              res_valid <= 1'b1;
              done      <= 1'b1;
              if (best_found) begin
                res       <= best_idx;
                max_score <= best_score;
              end else begin
                res       <= 8'hFF;
                max_score <= '0;
              end
              if (!(&mask)) err[2] <= 1'b1;
            end else begin
              if (take) begin
                best_found <= 1'b1;
                best_idx   <= 8'(idx);
                best_score <= cur_score;
              end
              idx <= idx + 1'b1;
            end
          end
          default: ; // IDLE and DONE wait for start
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_argmax_result.sv
// Directed bench for cnn_argmax_result: argmax, ties, error flags, abort,
// late writes and asynchronous reset.
module tb_cnn_argmax_result;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        layer_fin = 1'b0;
  logic [7:0]  res;
  logic        res_valid;
  logic        done;
  logic [15:0] max_score;
  logic        busy;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  cnn_argmax_result dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .layer_fin(layer_fin),
    .res(res), .res_valid(res_valid), .done(done), .max_score(max_score),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // advance one edge; sample point is 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fin();
    layer_fin = 1'b1;
    step();
    layer_fin = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL reset_res got %h exp 00", res); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (max_score !== 16'h0) begin errors++; $display("FAIL reset_max got %h exp 0000", max_score); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", err); end
  endtask

  task automatic test_basic();
    int sc[10] = '{-5, 3, 12, 7, 0, -100, 11, 2, 1, 4};
    int cyc;
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    checks++; if (res !== 8'hFF) begin errors++; $display("FAIL basic_res_armed got %h exp ff", res); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_armed got %b exp 0", res_valid); end
    for (int i = 0; i < 10; i++) wr(32'(i), 16'(sc[i]));
    fin();
    wait_done(cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL basic_latency got %0d exp 11", cyc); end
    checks++; if (res !== 8'd2) begin errors++; $display("FAIL basic_res got %0d exp 2", res); end
    checks++; if (max_score !== 16'd12) begin errors++; $display("FAIL basic_max got %h exp 000c", max_score); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL basic_err got %b exp 000", err); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (res !== 8'd2) begin errors++; $display("FAIL basic_res_hold got %0d exp 2", res); end
  endtask

  task automatic test_tie();
    int cyc;
    do_start();
    for (int i = 0; i < 10; i++) wr(32'(i), (i == 4 || i == 7) ? 16'hFFFF : 16'(-300));
    fin();
    wait_done(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tie_done got %b exp 1", done); end
    checks++; if (res !== 8'd4) begin errors++; $display("FAIL tie_res got %0d exp 4", res); end
    checks++; if (max_score !== 16'hFFFF) begin errors++; $display("FAIL tie_max got %h exp ffff", max_score); end
  endtask

  task automatic test_boundary();
    int cyc;
    do_start();
    for (int i = 0; i < 10; i++) if (i != 3) wr(32'(i), 16'd0);
    wr(32'd10, 16'd9999);
    wr(32'd3, 16'd5);
    wr(32'd3, 16'd50);
    wr(32'h8000_0003, 16'd77);
    fin();
    wait_done(cyc);
    checks++; if (err !== 3'b011) begin errors++; $display("FAIL bound_err got %b exp 011", err); end
    checks++; if (res !== 8'd3) begin errors++; $display("FAIL bound_res got %0d exp 3", res); end
    checks++; if (max_score !== 16'd50) begin errors++; $display("FAIL bound_max got %0d exp 50", max_score); end
  endtask

  // last write coincides with layer_fin; writes during SCAN must be dropped
  task automatic test_late_write();
    int sc[10] = '{-5, 3, 12, 7, 0, -100, 11, 2, 1, 4};
    int cyc;
    do_start();
    for (int i = 0; i < 10; i++) if (i != 8) wr(32'(i), 16'(sc[i]));
    wr_en = 1'b1; wr_addr = 32'd8; wr_data = 16'd40; layer_fin = 1'b1;
    step();
    layer_fin = 1'b0;
    wr_addr = 32'd0; wr_data = 16'd32767;
    step(); step(); step();
    wr_en = 1'b0;
    wait_done(cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL late_latency got %0d exp 8", cyc); end
    checks++; if (res !== 8'd8) begin errors++; $display("FAIL late_res got %0d exp 8", res); end
    checks++; if (max_score !== 16'd40) begin errors++; $display("FAIL late_max got %0d exp 40", max_score); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL late_err got %b exp 000", err); end
  endtask

  task automatic test_abort();
    int  cyc;
    logic seen_done, seen_valid;
    do_start();
    for (int i = 0; i < 10; i++) wr(32'(i), (i == 9) ? 16'd500 : 16'd1);
    fin();
    step(); step(); step();
    do_start();
    seen_done = 1'b0; seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen_done  |= done;
      seen_valid |= res_valid;
      step();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", seen_done); end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", seen_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", busy); end
    wr(32'd1, 16'd20);
    fin();
    wait_done(cyc);
    checks++; if (res !== 8'd1) begin errors++; $display("FAIL abort_res got %0d exp 1", res); end
    checks++; if (max_score !== 16'd20) begin errors++; $display("FAIL abort_max got %0d exp 20", max_score); end
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL abort_err got %b exp 100", err); end
  endtask

  task automatic test_missing();
    int cyc;
    do_start();
    fin();
    wait_done(cyc);
    checks++; if (res !== 8'hFF) begin errors++; $display("FAIL miss_none_res got %h exp ff", res); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL miss_none_valid got %b exp 1", res_valid); end
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL miss_none_err got %b exp 100", err); end
    checks++; if (max_score !== 16'h0) begin errors++; $display("FAIL miss_none_max got %h exp 0000", max_score); end
    do_start();
    wr(32'd6, 16'hFFF8);
    fin();
    wait_done(cyc);
    checks++; if (res !== 8'd6) begin errors++; $display("FAIL miss_one_res got %0d exp 6", res); end
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL miss_one_err got %b exp 100", err); end
    checks++; if (max_score !== 16'hFFF8) begin errors++; $display("FAIL miss_one_max got %h exp fff8", max_score); end
  endtask

  // entered while in DONE holding res=6, err=100
  task automatic test_async_reset();
    logic seen_done;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL areset_res got %h exp 00", res); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", res_valid); end
    checks++; if (max_score !== 16'h0) begin errors++; $display("FAIL areset_max got %h exp 0000", max_score); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL areset_err got %b exp 000", err); end
    step();
    #2 rst_n = 1'b1;
    layer_fin = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_done |= done | res_valid | busy;
    end
    layer_fin = 1'b0;
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL fin_no_start got %b exp 0", seen_done); end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_tie();
    test_boundary();
    test_late_write();
    test_abort();
    test_missing();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_argmax_result.md
# cnn_argmax_result

Classification result stage downstream of the third dense layer in the CNN inference pipeline. It captures the dense-3 write stream (address, data, write enable), holds one signed score per class, and, once dense-3 reports completion, scans the scores to find the winning class index. The index drives the system's 8-bit `res` output, with a valid flag and sticky error flags for the top-level sequencer.

## Interface
- `NUM_CLASSES`, 10: number of class scores; legal range 2..255.
- `DATA_WIDTH`, 16: score width; two's-complement signed.
- `ADDR_WIDTH`, 32: width of the incoming write address.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; arms capture for a new image.
- `wr_en`  in  1  dense-3 output write strobe.
- `wr_addr`  in  ADDR_WIDTH  class index of the write.
- `wr_data`  in  DATA_WIDTH  signed score.
- `layer_fin`  in  1  dense-3 `work_finished` level.
- `res`  out  8  winning class index; 8'hFF when there is no result.
- `res_valid`  out  1  high while `res` holds a finished result.
- `done`  out  1  one-cycle pulse when the result is produced.
- `max_score`  out  DATA_WIDTH  score of the winning class.
- `busy`  out  1  high in COLLECT and SCAN.
- `err`  out  3  sticky flags: {missing, duplicate, out_of_range}.

## Operation
- The block is a state machine with four states: IDLE, COLLECT, SCAN, DONE.
- **IDLE**
  - `start` moves the block to COLLECT.
  - On entry to COLLECT: clear the written-mask and `err`, deassert `res_valid`, load `res`=8'hFF.
  - All other inputs are ignored.
- **COLLECT**
  - `wr_en` with `wr_addr` < NUM_CLASSES stores `wr_data` in `score[wr_addr]` and sets `mask[wr_addr]`.
  - If that mask bit was already set, the new data overwrites the old value and `err[1]` is set.
  - `wr_en` with `wr_addr` >= NUM_CLASSES is dropped and sets `err[0]`. All 32 address bits are compared; no truncation.
  - `layer_fin`=1 moves the block to SCAN on the next edge. A write in that same cycle is still accepted.
- **SCAN**
  - Visits one index per cycle, idx = 0..NUM_CLASSES-1.
  - Running best starts as "none". An index replaces the best only if its mask bit is set and it is the first set index, or its score is strictly greater (signed) than the best.
  - Ties therefore go to the lowest index.
  - `wr_en` is ignored in SCAN.
- **DONE**
  - On entry, the following are registered:
    - `res` = best index, zero-extended to 8 bits.
    - `max_score` = best score.
    - `res_valid`=1 and `done`=1 for that one cycle.
  - If no mask bit was set: `res`=8'hFF, `max_score`=0, `err[2]`=1, and `res_valid`=1 still.
  - If only some mask bits were set: set `err[2]` and produce a result from the written scores only.
  - The block stays in DONE, holding its outputs, until `start`.
  - `start` in DONE follows the same entry behaviour as from IDLE.
- **`start` in COLLECT or SCAN:** aborts and re-enters COLLECT with the same clearing. No `done` pulse is produced.
- `layer_fin` is level-sampled in COLLECT only. A level still high in DONE or IDLE has no effect.
- **Reset:**
  - State goes to IDLE.
  - `res`=0, `res_valid`=0, `done`=0, `max_score`=0, `busy`=0, `err`=0.
  - `score` and `mask` clear.
  - Reset mid-SCAN discards everything.

## Timing
- `start` at edge T: COLLECT from T+1, so `busy`=1 and `res_valid`=0 from T+1.
- `layer_fin` sampled high at edge T in COLLECT:
  - SCAN covers T+1..T+NUM_CLASSES.
  - DONE is entered at edge T+NUM_CLASSES+1, with `res`, `res_valid`, `done` and `max_score` updated there.
  - Latency is NUM_CLASSES+1 cycles; 11 at the default.
- `busy` falls at the same edge at which `res_valid` rises.
- `done` is high for exactly one cycle per completed image.
- The comparator is one signed DATA_WIDTH compare per cycle, with no arithmetic growth.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic argmax.** Reset, `start`, write scores {-5,3,12,7,0,-100,11,2,1,4} to addresses 0..9, pulse `layer_fin`.
  - Expect `done` 11 cycles later, `res`=2, `max_score`=12, `err`=0.
- **Tie and negative scores.** All scores = -300 except addr 4 = addr 7 = -1.
  - Expect `res`=4, `max_score`=16'hFFFF.
- **Boundary errors.** Write addr 10 (data 9999), addr 32'h8000_0003, and addr 3 twice (5, then 50); all others 0.
  - Expect `err`=3'b011, `res`=3, `max_score`=50.
- **Missing scores.**
  - No writes, then `layer_fin`: expect `res`=8'hFF, `res_valid`=1, `err`=3'b100.
  - Only addr 6 written with -8: expect `res`=6, `err[2]`=1.
- **Abort and late writes.**
  - `start` mid-SCAN: no `done`, `res_valid` stays 0, old scores are lost.
  - `wr_en` during SCAN to addr 0 with 32767: ignored, result unchanged.
- **Reset behaviour.**
  - Assert `rst_n`=0 asynchronously in DONE: outputs go to their reset values immediately, without waiting for a clock edge.
  - Holding `layer_fin` high after reset, with no `start`, gives no `done`.
